// File: rtl/bus_arb_rr.sv
// Round-robin bus arbiter connecting NM masters to NS slaves.
// Slaves are decoded from the owner's upper address bits; read data returns one cycle later.
module bus_arb_rr #(
  parameter int NM    = 2,
  parameter int NS    = 4,
  parameter int AW    = 16,
  parameter int DW    = 64,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_wr,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_dout,
  input  logic [NS*DW-1:0] s_dout,
  output logic [NM-1:0]    m_grant,
  output logic [DW-1:0]    m_din,
  output logic             m_rvalid,
  output logic [NS-1:0]    s_sel,
  output logic [AW-1:0]    s_addr,
  output logic             s_wr,
  output logic [DW-1:0]    s_din,
  output logic             dec_err
);

  localparam int MW = (NM > 2) ? 2 : 1;
  localparam logic [SEL_W:0] NS_LIM = (SEL_W+1)'(NS);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          r_state;
  logic [MW-1:0]   r_owner;
  logic [MW-1:0]   r_last;
  logic [NM-1:0]   r_grant;
  logic [DW-1:0]   r_din;
  logic            r_rvalid;

  logic            w_owned;
  logic            w_ownReq;
  logic            w_ownWr;
  logic [AW-1:0]   w_ownAddr;
  logic [DW-1:0]   w_ownDout;
  logic [SEL_W-1:0] w_idx;
  logic            w_inRange;
  logic [DW-1:0]   w_rdData;
  logic [MW-1:0]   w_pickBase;
  logic [MW-1:0]   w_pick;

  // First requester after 'last', walking upward with wrap-around.
  function automatic logic [MW-1:0] rrPick(input logic [NM-1:0] req, input logic [MW-1:0] last);
    logic [MW-1:0] pick;
    int idx;
    pick = last;
    for (int n = NM; n >= 1; n--) begin
      idx = (int'(last) + n) % NM;
      if (req[idx]) pick = MW'(idx);
    end
    return pick;
  endfunction

  assign w_owned = (r_state == OWNED);

  always_comb begin
    w_ownReq  = 1'b0;
    w_ownWr   = 1'b0;
    w_ownAddr = '0;
    w_ownDout = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_owner == MW'(i)) begin
        w_ownReq  = m_req[i];
        w_ownWr   = m_wr[i];
        w_ownAddr = m_addr[i*AW +: AW];
        w_ownDout = m_dout[i*DW +: DW];
      end
    end
  end

  assign w_idx     = w_ownAddr[AW-1 -: SEL_W];
  assign w_inRange = ({1'b0, w_idx} < NS_LIM);

  always_comb begin
    s_sel    = '0;
    w_rdData = '0;
    for (int k = 0; k < NS; k++) begin
      if (w_idx == SEL_W'(k)) begin
        s_sel[k] = w_owned;
        w_rdData = s_dout[k*DW +: DW];
      end
    end
  end

  assign dec_err = w_owned && !w_inRange;
  assign s_addr  = w_owned ? w_ownAddr : '0;
  assign s_din   = w_owned ? w_ownDout : '0;
  assign s_wr    = w_owned && w_inRange && w_ownWr;

  // While owned, the owner's request bit is already 0 when a handover is picked.
  assign w_pickBase = w_owned ? r_owner : r_last;
  assign w_pick     = rrPick(m_req, w_pickBase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_last   <= MW'(NM-1);
      r_grant  <= '0;
      r_din    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_owned && !w_ownWr) begin
        if (w_inRange) begin
          r_din    <= w_rdData;
          r_rvalid <= 1'b1;
        end else begin
          r_din    <= '0;
        end
      end

      case (r_state)
        IDLE: begin
          if (|m_req) begin
            r_owner <= w_pick;
            r_grant <= {{(NM-1){1'b0}}, 1'b1} << w_pick;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (!w_ownReq) begin
            r_last <= r_owner;
            if (|m_req) begin
              r_owner <= w_pick;
              r_grant <= {{(NM-1){1'b0}}, 1'b1} << w_pick;
            end else begin
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_grant  = r_grant;
  assign m_din    = r_din;
  assign m_rvalid = r_rvalid;

endmodule

// File: tb/tb_bus_arb_rr.sv
// Scoreboard bench for bus_arb_rr: one NS=4 instance and one NS=3 instance for unmapped decode.
module tb_bus_arb_rr;

  typedef struct {
    logic        isB;
    logic [1:0]  grant;
    logic [3:0]  sel;
    logic [15:0] addr;
    logic        wr;
    logic [63:0] sdin;
    logic        decErr;
    logic [63:0] mdin;
    logic        rvalid;
  } expT;

  logic clk;
  logic reset_n;

  logic [1:0]   aReq, aWr, aGrant;
  logic [31:0]  aAddr;
  logic [127:0] aDout;
  logic [255:0] aSdout;
  logic [63:0]  aMdin, aSdin;
  logic         aRvalid, aSwr, aDecErr;
  logic [3:0]   aSel;
  logic [15:0]  aSaddr;

  logic [1:0]   bReq, bWr, bGrant;
  logic [31:0]  bAddr;
  logic [127:0] bDout;
  logic [191:0] bSdout;
  logic [63:0]  bMdin, bSdin;
  logic         bRvalid, bSwr, bDecErr;
  logic [2:0]   bSel;
  logic [15:0]  bSaddr;

  expT expQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  stepNo = 0;

  bus_arb_rr #(.NM(2), .NS(4), .AW(16), .DW(64), .SEL_W(2)) dutA (
    .clk(clk), .reset_n(reset_n), .m_req(aReq), .m_wr(aWr), .m_addr(aAddr),
    .m_dout(aDout), .s_dout(aSdout), .m_grant(aGrant), .m_din(aMdin),
    .m_rvalid(aRvalid), .s_sel(aSel), .s_addr(aSaddr), .s_wr(aSwr),
    .s_din(aSdin), .dec_err(aDecErr)
  );

  bus_arb_rr #(.NM(2), .NS(3), .AW(16), .DW(64), .SEL_W(2)) dutB (
    .clk(clk), .reset_n(reset_n), .m_req(bReq), .m_wr(bWr), .m_addr(bAddr),
    .m_dout(bDout), .s_dout(bSdout), .m_grant(bGrant), .m_din(bMdin),
    .m_rvalid(bRvalid), .s_sel(bSel), .s_addr(bSaddr), .s_wr(bSwr),
    .s_din(bSdin), .dec_err(bDecErr)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic expT mkExp(input logic isB, input logic [1:0] grant, input logic [3:0] sel,
                                input logic [15:0] addr, input logic wr, input logic [63:0] sdin,
                                input logic decErr, input logic [63:0] mdin, input logic rvalid);
    expT e;
    e.isB = isB; e.grant = grant; e.sel = sel; e.addr = addr; e.wr = wr;
    e.sdin = sdin; e.decErr = decErr; e.mdin = mdin; e.rvalid = rvalid;
    return e;
  endfunction

  // Pops the oldest expectation and compares it with the selected instance's outputs.
  task automatic compareStep();
    expT e;
    string p;
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 64'd1, 64'd0);
      return;
    end
    e = expQ.pop_front();
    p = $sformatf("%s%0d", e.isB ? "b" : "a", stepNo);
    if (!e.isB) begin
      checkOutput({p, ".grant"},  64'(aGrant),  64'(e.grant));
      checkOutput({p, ".sel"},    64'(aSel),    64'(e.sel));
      checkOutput({p, ".addr"},   64'(aSaddr),  64'(e.addr));
      checkOutput({p, ".wr"},     64'(aSwr),    64'(e.wr));
      checkOutput({p, ".sdin"},   aSdin,        e.sdin);
      checkOutput({p, ".decErr"}, 64'(aDecErr), 64'(e.decErr));
      checkOutput({p, ".mdin"},   aMdin,        e.mdin);
      checkOutput({p, ".rvalid"}, 64'(aRvalid), 64'(e.rvalid));
    end else begin
      checkOutput({p, ".grant"},  64'(bGrant),  64'(e.grant));
      checkOutput({p, ".sel"},    64'(bSel),    64'(e.sel));
      checkOutput({p, ".addr"},   64'(bSaddr),  64'(e.addr));
      checkOutput({p, ".wr"},     64'(bSwr),    64'(e.wr));
      checkOutput({p, ".sdin"},   bSdin,        e.sdin);
      checkOutput({p, ".decErr"}, 64'(bDecErr), 64'(e.decErr));
      checkOutput({p, ".mdin"},   bMdin,        e.mdin);
      checkOutput({p, ".rvalid"}, 64'(bRvalid), 64'(e.rvalid));
    end
  endtask

  // Drives one cycle of inputs, queues the expected post-edge outputs, then checks them.
  task automatic applyStimulus(input logic isB, input logic [1:0] req, input logic [1:0] wr,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [63:0] d0, input logic [63:0] d1, input expT e);
    if (!isB) begin
      aReq = req; aWr = wr; aAddr = {a1, a0}; aDout = {d1, d0};
    end else begin
      bReq = req; bWr = wr; bAddr = {a1, a0}; bDout = {d1, d0};
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    stepNo++;
    compareStep();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".aGrant"},  64'(aGrant),  64'd0);
    checkOutput({tag, ".aMdin"},   aMdin,        64'd0);
    checkOutput({tag, ".aRvalid"}, 64'(aRvalid), 64'd0);
    checkOutput({tag, ".aSel"},    64'(aSel),    64'd0);
    checkOutput({tag, ".aAddr"},   64'(aSaddr),  64'd0);
    checkOutput({tag, ".aWr"},     64'(aSwr),    64'd0);
    checkOutput({tag, ".aSdin"},   aSdin,        64'd0);
    checkOutput({tag, ".aDecErr"}, 64'(aDecErr), 64'd0);
    checkOutput({tag, ".bGrant"},  64'(bGrant),  64'd0);
    checkOutput({tag, ".bSel"},    64'(bSel),    64'd0);
  endtask

  localparam logic [63:0] D0 = 64'h0A0A;
  localparam logic [63:0] D1 = 64'd32;

  initial begin
    reset_n = 1'b0;
    aReq = 2'b11; aWr = 2'b10; aAddr = {16'hC000, 16'h4010}; aDout = {D1, D0};
    aSdout = {64'h3333, 64'h2222, 64'd1234, 64'h1111};
    bReq = 2'b11; bWr = 2'b00; bAddr = {16'h8000, 16'h4010}; bDout = {D1, D0};
    bSdout = {64'h2222, 64'd1234, 64'h1111};

    // Reset held across edges with both masters requesting.
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("resetHold");
    bReq = 2'b00;
    #2;
    reset_n = 1'b1;

    // Read of slave 1 by master 0, then round-robin handovers and a write by master 1.
    applyStimulus(0, 2'b11, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'd0, 0));
    applyStimulus(0, 2'b11, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'd1234, 1));
    applyStimulus(0, 2'b10, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b10, 4'b1000, 16'hC000, 1, D1, 0, 64'd1234, 1));
    applyStimulus(0, 2'b11, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b10, 4'b1000, 16'hC000, 1, D1, 0, 64'd1234, 0));
    applyStimulus(0, 2'b01, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'd1234, 0));
    aSdout[64 +: 64] = 64'd5678;
    applyStimulus(0, 2'b00, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b00, 4'b0000, 16'h0000, 0, 64'd0, 0, 64'd5678, 1));
    applyStimulus(0, 2'b00, 2'b10, 16'h4010, 16'hC000, D0, D1,
                  mkExp(0, 2'b00, 4'b0000, 16'h0000, 0, 64'd0, 0, 64'd5678, 0));

    // From idle with last owner 0, master 1 reads slave 2.
    applyStimulus(0, 2'b10, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b10, 4'b0100, 16'h8004, 0, D1, 0, 64'd5678, 0));
    applyStimulus(0, 2'b10, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b10, 4'b0100, 16'h8004, 0, D1, 0, 64'h2222, 1));
    applyStimulus(0, 2'b11, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b10, 4'b0100, 16'h8004, 0, D1, 0, 64'h2222, 1));
    applyStimulus(0, 2'b01, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'h2222, 1));

    // Reset dropped between edges while master 0 is mid-read.
    #2;
    reset_n = 1'b0;
    aReq = 2'b11;
    #1;
    checkAllZero("resetMid");
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // After release master 0 has priority; then with last=0 master 1 wins from idle.
    applyStimulus(0, 2'b11, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'd0, 0));
    applyStimulus(0, 2'b00, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b00, 4'b0000, 16'h0000, 0, 64'd0, 0, 64'd5678, 1));
    applyStimulus(0, 2'b11, 2'b00, 16'h4010, 16'h8004, D0, D1,
                  mkExp(0, 2'b10, 4'b0100, 16'h8004, 0, D1, 0, 64'd5678, 0));

    // NS=3 instance: mapped read, then unmapped read and write at 0xC000.
    applyStimulus(1, 2'b01, 2'b00, 16'h4010, 16'h0000, D0, D1,
                  mkExp(1, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'd0, 0));
    applyStimulus(1, 2'b01, 2'b00, 16'h4010, 16'h0000, D0, D1,
                  mkExp(1, 2'b01, 4'b0010, 16'h4010, 0, D0, 0, 64'd1234, 1));
    applyStimulus(1, 2'b01, 2'b00, 16'hC000, 16'h0000, D0, D1,
                  mkExp(1, 2'b01, 4'b0000, 16'hC000, 0, D0, 1, 64'd0, 0));
    applyStimulus(1, 2'b01, 2'b01, 16'hC000, 16'h0000, D0, D1,
                  mkExp(1, 2'b01, 4'b0000, 16'hC000, 0, D0, 1, 64'd0, 0));

    if (expQ.size() != 0) checkOutput("scoreboardLeftover", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bus_arb_rr.md
BUS_ARB_RR -- requirements
Module: bus_arb_rr

Interface
REQ-001 Parameter NM, default 2, number of masters (range 2..4).
REQ-002 Parameter NS, default 4, number of slaves (range 2..8, NS <= 2**SEL_W).
REQ-003 Parameter AW, default 16, address width.
REQ-004 Parameter DW, default 64, data width.
REQ-005 Parameter SEL_W, default 2, number of upper address bits used for slave decode.
REQ-006 Port list:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- m_req  in  NM  request, one bit per master.
- m_wr  in  NM  write enable per master (1 = write, 0 = read).
- m_addr  in  NM*AW  packed master addresses; master i occupies bits [i*AW +: AW].
- m_dout  in  NM*DW  packed master write data.
- s_dout  in  NS*DW  packed slave read data; slave k occupies bits [k*DW +: DW].
- m_grant  out  NM  one-hot grant, registered.
- m_din  out  DW  read data returned to the owner, registered.
- m_rvalid  out  1  m_din updated by a mapped read, registered.
- s_sel  out  NS  one-hot slave select.
- s_addr  out  AW  address forwarded to slaves.
- s_wr  out  1  write strobe forwarded to slaves.
- s_din  out  DW  write data forwarded to slaves.
- dec_err  out  1  owner address is unmapped.

Function
REQ-007 The arbiter SHALL have two states: IDLE (no owner) and OWNED (exactly one m_grant bit set). It SHALL also keep a last-owner index.
REQ-008 IDLE: on any edge where m_req != 0, the arbiter SHALL grant the first requesting master, searching from (last+1) mod NM upward with wrap-around, and go to OWNED. The grant is visible after that edge.
REQ-009 OWNED, owner's m_req still 1: grant SHALL be held. There is no preemption, regardless of other requests.
REQ-010 OWNED, owner's m_req 0 at an edge:
- last SHALL be set to the owner.
- If another master requests, grant SHALL move at that same edge to the next requester in round-robin order, with no idle cycle.
- Otherwise the arbiter SHALL go to IDLE with m_grant = 0.
REQ-011 The slave index SHALL be idx = owner m_addr[AW-1 -: SEL_W].
REQ-012 If idx < NS, s_sel[idx] SHALL be 1 and dec_err SHALL be 0.
REQ-013 If idx >= NS, s_sel SHALL be all 0 and dec_err SHALL be 1.
REQ-014 s_addr, s_din and s_wr SHALL combinationally mirror the owner's m_addr, m_dout and m_wr. s_wr SHALL be 0 when dec_err is 1.
REQ-015 With no owner, s_sel, s_addr, s_wr, s_din and dec_err SHALL all be 0.
REQ-016 Mapped read (owner present, m_wr=0, dec_err=0) at an edge: m_din SHALL load s_dout of slave idx and m_rvalid SHALL be 1 for the following cycle. Read latency is one cycle.
REQ-017 Unmapped read at an edge: m_din SHALL load 0 and m_rvalid SHALL be 0.
REQ-018 Write cycle or no owner at an edge: m_din SHALL hold its value and m_rvalid SHALL be 0.
REQ-019 m_req bits of non-owners SHALL NOT affect any s_* output.

Reset
REQ-020 While reset_n is 0, regardless of clk:
- m_grant = 0, m_din = 0, m_rvalid = 0.
- state = IDLE, last = NM-1, so master 0 has first priority.
- All combinational outputs SHALL therefore be 0.
REQ-021 Reset asserted mid-transaction SHALL abort the transaction immediately. The first grant after reset release SHALL follow REQ-008.

Verification (NM=2, NS=4, SEL_W=2 unless stated)
REQ-022 Reset: hold reset_n=0 with m_req=2'b11 -> every output reads 0; after release the first edge grants master 0 (m_grant=01).
REQ-023 Master 0 reads 0x4010 with slave 1 s_dout=1234:
- After one edge: m_grant=01, s_sel=0010, s_addr=0x4010, s_wr=0.
- Next edge: m_din=1234, m_rvalid=1.
REQ-024 Round-robin:
- Both masters request -> master 0 granted.
- Master 0 drops m_req -> m_grant=10 at the same edge.
- Master 1 drops while master 0 requests -> m_grant=01.
- Both drop -> m_grant=00.
REQ-025 Master 1 writes addr 0xC000, m_dout=32 -> s_sel=1000, s_wr=1, s_din=32; m_rvalid stays 0 and m_din is unchanged.
REQ-026 Instance with NS=3, read addr 0xC000 -> s_sel=000, dec_err=1, s_wr=0; next edge m_din=0, m_rvalid=0.
REQ-027 Drop reset_n mid-read, between edges -> m_grant, m_din, m_rvalid and s_sel go to 0 immediately, without waiting for clk.
